// File: rtl/morse_pkg.sv
// Shared constants, slot record and glyph-address helper for the Morse
// character display path.
package morse_pkg;

    localparam int NUM_SLOTS = 8;
    localparam int CODE_W    = 6;
    localparam int ADDR_W    = 11;
    localparam int COUNT_W   = 4;
    localparam int POS_W     = 3;

    localparam logic [CODE_W-1:0]  MAX_CODE   = CODE_W'(35);
    localparam logic [ADDR_W-1:0]  BLANK_ADDR = '0;
    localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(NUM_SLOTS);

    typedef struct packed {
        logic              occupied;
        logic [CODE_W-1:0] code;
    } slot_t;

    // Glyph 0 of the font ROM is the blank, so code n lives at glyph n+1.
    function automatic logic [ADDR_W-1:0] glyph_addr(input slot_t s, input int unsigned stride);
        logic [31:0] wide;
        if (!s.occupied) begin
            return BLANK_ADDR;
        end
        wide = (32'(s.code) + 32'd1) * stride;
        return wide[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/scan_divider.sv
// Free-running 0..SCAN_DIV-1 counter; advance pulses on the wrap cycle.
module scan_divider
    import morse_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic advance
);

    localparam logic [7:0] LAST = 8'(SCAN_DIV - 1);

    logic [7:0] count;

    assign advance = (count == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (advance) begin
            count <= '0;
        end else begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/char_slot_buffer.sv
// Eight-slot scrolling character buffer feeding glyph addresses to the
// VGA scan-out, one slot per SCAN_DIV cycles.
module char_slot_buffer
    import morse_pkg::*;
#(
    parameter int unsigned SCAN_DIV    = 4,
    parameter int unsigned FONT_STRIDE = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                char_valid,
    input  logic [CODE_W-1:0]   char_code,
    input  logic                backspace,
    input  logic                clear,
    output logic [POS_W-1:0]    display_position,
    output logic [ADDR_W-1:0]   addr_fixed1,
    output logic [COUNT_W-1:0]  char_count,
    output logic                full
);

    slot_t             slots [NUM_SLOTS];
    logic              advance;
    logic [POS_W-1:0]  pos_next;
    logic [POS_W-1:0]  wr_idx;
    logic [POS_W-1:0]  last_idx;
    logic              code_ok;

    scan_divider #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan_divider (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (advance)
    );

    assign full     = (char_count == FULL_COUNT);
    assign code_ok  = (char_code <= MAX_CODE);
    assign wr_idx   = char_count[POS_W-1:0];
    // At char_count == 8 the low bits are 0, so last_idx correctly wraps to 7.
    assign last_idx = wr_idx - POS_W'(1);
    assign pos_next = advance ? display_position + POS_W'(1) : display_position;

    // NOTE: the slot array is reset explicitly because empty slots must read
    // as the blank glyph straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots[i] <= '0;
            end
            char_count <= '0;
        end else if (clear) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots[i] <= '0;
            end
            char_count <= '0;
        end else if (backspace) begin
            if (char_count != '0) begin
                slots[last_idx].occupied <= 1'b0;
                char_count <= char_count - COUNT_W'(1);
            end
        end else if (char_valid && code_ok) begin
            if (!full) begin
                slots[wr_idx] <= '{occupied: 1'b1, code: char_code};
                char_count    <= char_count + COUNT_W'(1);
            end else begin
                for (int i = 0; i < NUM_SLOTS - 1; i++) begin
                    slots[i] <= slots[i+1];
                end
                slots[NUM_SLOTS-1] <= '{occupied: 1'b1, code: char_code};
            end
        end
    end

    // Position and address move together; the address reads the slot that the
    // position is about to show, giving one cycle of write-to-display latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display_position <= '0;
            addr_fixed1      <= BLANK_ADDR;
        end else begin
            display_position <= pos_next;
            addr_fixed1      <= glyph_addr(slots[pos_next], FONT_STRIDE);
        end
    end

endmodule
